// File: rtl/voice_timer_sched.sv
// Shared 16-bit interval timer for the voice path, time-multiplexed between NUM_REQ requesters.
// A round-robin arbiter picks a requester from IDLE, the timer counts qualified ticks up to the
// latched length, and the winner receives a one-cycle done pulse.
// Optional build macro: VOICE_TIMER_SCHED_PRIO_EN selects fixed priority (lowest index wins)
// and removes the round-robin pointer.
module voice_timer_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_tick,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*CNT_W-1:0] i_len,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic [IdxW-1:0]    scan_base;
  logic               pick_vld;
  logic [IdxW-1:0]    pick_idx;
  logic [CNT_W-1:0]   pick_len;
  int unsigned        scan_cand;

`ifdef VOICE_TIMER_SCHED_PRIO_EN
  // Fixed priority: every scan starts at requester 0.
  assign scan_base = '0;
`else
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] next_ptr;

  assign scan_base = ptr_q;
  // Explicit wrap so non-power-of-two NUM_REQ returns to 0.
  assign next_ptr  = (32'(gnt_idx_q) == NUM_REQ - 1) ? '0 : gnt_idx_q + IdxW'(1);

  // Round-robin pointer: first requester to check on the next arbitration.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Arbiter: first set request scanning upward from scan_base with wrap-around.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_len  = '0;
    scan_cand = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_cand = (32'(scan_base) + i) % NUM_REQ;
      if (!pick_vld && i_req[scan_cand]) begin
        pick_vld = 1'b1;
        pick_idx = IdxW'(scan_cand);
        pick_len = i_len[scan_cand*CNT_W +: CNT_W];
      end
    end
  end

  // Next-state logic plus registered-output next values.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
`ifndef VOICE_TIMER_SCHED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d   = StLoad;
          gnt_idx_d = pick_idx;
          len_d     = pick_len;
          cnt_d     = '0;
        end
      end
      StLoad: begin
        if (!i_req[gnt_idx_q]) begin
          // Abort: no done pulse, counter holds, pointer still moves on.
          state_d = StIdle;
`ifndef VOICE_TIMER_SCHED_PRIO_EN
          ptr_d   = next_ptr;
`endif
        end else if (len_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!i_req[gnt_idx_q]) begin
          state_d = StIdle;
`ifndef VOICE_TIMER_SCHED_PRIO_EN
          ptr_d   = next_ptr;
`endif
        end else if (i_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Terminal compare fires before the counter can wrap, even at the maximum length.
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
`ifndef VOICE_TIMER_SCHED_PRIO_EN
        ptr_d   = next_ptr;
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    gnt_d  = '0;
    if (busy_d) begin
      gnt_d[gnt_idx_d] = 1'b1;
    end
    done_d = '0;
    if (state_d == StDone) begin
      done_d[gnt_idx_d] = 1'b1;
    end
  end

  // State, latched transaction data and registered outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_done = done_q;
  assign o_busy = busy_q;
  assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_voice_timer_sched.sv
// Directed self-checking bench for voice_timer_sched (NUM_REQ=4, CNT_W=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_voice_timer_sched;

  localparam int unsigned NumReq = 4;
  localparam int unsigned CntW   = 16;

  logic                     clk;
  logic                     i_rst_n;
  logic                     i_tick;
  logic [NumReq-1:0]        i_req;
  logic [NumReq*CntW-1:0]   i_len;
  logic [NumReq-1:0]        o_gnt;
  logic [NumReq-1:0]        o_done;
  logic                     o_busy;
  logic [CntW-1:0]          o_cnt;

  int n_vec = 0;
  int n_err = 0;

  voice_timer_sched #(
    .NUM_REQ (NumReq),
    .CNT_W   (CntW)
  ) u_dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_tick),
    .i_req   (i_req),
    .i_len   (i_len),
    .o_gnt   (o_gnt),
    .o_done  (o_done),
    .o_busy  (o_busy),
    .o_cnt   (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_len(input int k, input logic [CntW-1:0] v);
    i_len[k*CntW +: CntW] = v;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req   = '0;
    i_tick  = 1'b0;
    i_len   = '0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NumReq-1:0] exp_g;
    logic [31:0]       exp_c;

    // Reset state
    i_rst_n = 1'b1;
    i_req   = '0;
    i_tick  = 1'b0;
    i_len   = '0;
    #1 i_rst_n = 1'b0;
    #1;
    check_val("rst_gnt", 32'(o_gnt), 0);
    check_val("rst_done", 32'(o_done), 0);
    check_val("rst_busy", 32'(o_busy), 0);
    check_val("rst_cnt", 32'(o_cnt), 0);
    do_reset();

    // Single request, len 5, tick always high; i_len change mid-run must be ignored
    @(negedge clk);
    set_len(0, 16'd5);
    i_req  = 4'b0001;
    i_tick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_c = (k < 2) ? 0 : ((k > 6) ? 5 : 32'(k - 1));
      check_val("single_cnt", 32'(o_cnt), exp_c);
      check_val("single_gnt", 32'(o_gnt), (k <= 6) ? 32'h1 : 32'h0);
      check_val("single_done", 32'(o_done), (k == 6) ? 32'h1 : 32'h0);
      check_val("single_busy", 32'(o_busy), (k <= 6) ? 32'h1 : 32'h0);
      if (k == 2) set_len(0, 16'd9);
      if (k == 6) i_req = '0;
    end

    // Round-robin, all four requesting, all lengths 2
    do_reset();
    for (int k = 0; k < 4; k++) set_len(k, 16'd2);
    i_req  = 4'b1111;
    i_tick = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
`ifdef VOICE_TIMER_SCHED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << ((k / 5) % 4);
`endif
      check_val("rr_gnt", 32'(o_gnt), ((k % 5) < 4) ? 32'(exp_g) : 0);
      check_val("rr_done", 32'(o_done), ((k % 5) == 3) ? 32'(exp_g) : 0);
    end
    i_req = '0;

    // Zero length on requester 2
    do_reset();
    set_len(2, 16'd0);
    i_req  = 4'b0100;
    i_tick = 1'b1;
    @(negedge clk);
    check_val("zero_gnt", 32'(o_gnt), 32'h4);
    check_val("zero_done0", 32'(o_done), 0);
    @(negedge clk);
    check_val("zero_done", 32'(o_done), 32'h4);
    check_val("zero_cnt", 32'(o_cnt), 0);
    i_req = '0;
    @(negedge clk);
    check_val("zero_idle_busy", 32'(o_busy), 0);
    check_val("zero_idle_done", 32'(o_done), 0);

    // Len 3 with tick toggling; counter freezes on low-tick cycles
    set_len(0, 16'd3);
    i_req  = 4'b0001;
    i_tick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_c = (k < 2) ? 0 : ((k >= 6) ? 3 : 32'(k / 2));
      check_val("gap_cnt", 32'(o_cnt), exp_c);
      check_val("gap_done", 32'(o_done), (k == 6) ? 32'h1 : 32'h0);
      i_tick = (k % 2 == 1);
      if (k == 6) i_req = '0;
    end
    i_tick = 1'b1;

    // Abort requester 1 at count 40; pointer must move past it
    do_reset();
    set_len(1, 16'd100);
    set_len(2, 16'd7);
    i_req  = 4'b0110;
    i_tick = 1'b1;
    for (int c = 0; c < 200 && o_cnt != 16'd40; c++) @(negedge clk);
    check_val("abort_reach", 32'(o_cnt), 40);
    check_val("abort_gnt_before", 32'(o_gnt), 32'h2);
    i_req = 4'b0101;
    @(negedge clk);
    check_val("abort_busy", 32'(o_busy), 0);
    check_val("abort_gnt", 32'(o_gnt), 0);
    check_val("abort_done", 32'(o_done), 0);
    check_val("abort_cnt_hold", 32'(o_cnt), 40);
    @(negedge clk);
`ifdef VOICE_TIMER_SCHED_PRIO_EN
    check_val("abort_next_gnt", 32'(o_gnt), 32'h1);
`else
    check_val("abort_next_gnt", 32'(o_gnt), 32'h4);
`endif
    check_val("abort_next_cnt", 32'(o_cnt), 0);

    // Asynchronous reset in the middle of a run
    do_reset();
    set_len(3, 16'd50);
    i_req  = 4'b1000;
    i_tick = 1'b1;
    for (int c = 0; c < 200 && o_cnt != 16'd10; c++) @(negedge clk);
    check_val("midrst_reach", 32'(o_cnt), 10);
    i_rst_n = 1'b0;
    #1;
    check_val("midrst_gnt", 32'(o_gnt), 0);
    check_val("midrst_done", 32'(o_done), 0);
    check_val("midrst_busy", 32'(o_busy), 0);
    check_val("midrst_cnt", 32'(o_cnt), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_req   = 4'b1001;
    @(negedge clk);
    check_val("midrst_after_gnt", 32'(o_gnt), 32'h1);
    i_req = '0;

    // Requests 1 and 3 held: alternate under round-robin, 1 only under fixed priority
    do_reset();
    for (int k = 0; k < 4; k++) set_len(k, 16'd1);
    i_req  = 4'b1010;
    i_tick = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
`ifdef VOICE_TIMER_SCHED_PRIO_EN
      exp_g = 4'b0010;
`else
      exp_g = ((k / 4) % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      if (k % 4 == 0) check_val("pair_gnt", 32'(o_gnt), 32'(exp_g));
      if (k % 4 == 2) check_val("pair_done", 32'(o_done), 32'(exp_g));
      if (k == 15) i_req = 4'b1000;
    end
    @(negedge clk);
    check_val("pair_last_gnt", 32'(o_gnt), 32'h8);
    i_req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
